// File: rtl/sram_like_responder_pkg.sv
// Shared encodings and response-entry layout for the sram-like bus responder.
package sram_like_responder_pkg;

    localparam int DATA_W      = 32;
    localparam int RESP_CNT_W  = 4;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    typedef struct packed {
        logic                  is_write;
        logic [DATA_W-1:0]     rdata;
        logic [RESP_CNT_W-1:0] cnt;
    } resp_entry_t;

endpackage

// File: rtl/sram_like_responder_resp_fifo.sv
// In-order queue of pending responses; every stored entry counts down to its beat.
module sram_like_responder_resp_fifo
    import sram_like_responder_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         push,
    input  resp_entry_t                  push_entry,
    input  logic                         pop,
    output resp_entry_t                  head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    resp_entry_t       entries [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;

    assign head  = entries[rptr];
    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= (wptr == PTR_LAST) ? '0 : wptr + PTR_W'(1);
            if (pop)  rptr <= (rptr == PTR_LAST) ? '0 : rptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload is not reset: validity comes only from count/pointers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].cnt != '0) entries[i].cnt <= entries[i].cnt - RESP_CNT_W'(1);
        end
        if (push) entries[wptr] <= push_entry;
    end

endmodule

// File: rtl/sram_like_responder.sv
// Memory-side sram-like bus slave: word array, byte-lane writes, fixed-latency in-order beats.
module sram_like_responder
    import sram_like_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2,
    parameter int DEPTH      = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [31:0]       addr,
    input  logic [3:0]        wstrb,
    input  logic [31:0]       wdata,
    input  logic              addr_stall,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [31:0]       rdata
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [RESP_CNT_W-1:0] INIT_CNT = RESP_CNT_W'(LATENCY - 1);

    logic [DATA_W-1:0]     mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] idx;
    resp_entry_t           push_entry;
    resp_entry_t           head;
    logic                  full;
    logic                  empty;
    logic [CNT_W-1:0]      count;
    logic                  retire;
    logic                  accept;
    logic                  unused_bits;

    assign idx    = addr[ADDR_WIDTH+1:2];
    // Retire depends only on registered queue state, so addr_ok never sees req.
    assign retire  = ~empty & (head.cnt == '0);
    assign addr_ok = resetn & ~addr_stall & (~full | retire);
    assign accept  = req & addr_ok;

    assign unused_bits = ^{size, addr[31:ADDR_WIDTH+2], addr[1:0], head.is_write, count};

    always_comb begin
        push_entry          = '0;
        push_entry.is_write = wr;
        push_entry.rdata    = wr ? '0 : mem[idx];
        push_entry.cnt      = INIT_CNT;
    end

    always_ff @(posedge clk) begin
        if (accept && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    sram_like_responder_resp_fifo #(
        .DEPTH (DEPTH)
    ) u_resp_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (accept),
        .push_entry (push_entry),
        .pop        (retire),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (count)
    );

    // Output stage: one registered beat per retired entry.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_ok <= 1'b0;
            rdata   <= '0;
        end else begin
            data_ok <= retire;
            rdata   <= retire ? head.rdata : '0;
        end
    end

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench for sram_like_responder (ADDR_WIDTH=12, LATENCY=2, DEPTH=2).
module tb_sram_like_responder;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_stall;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    int checks   = 0;
    int failures = 0;

    sram_like_responder #(
        .ADDR_WIDTH (12),
        .LATENCY    (2),
        .DEPTH      (2)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req),
        .wr         (wr),
        .size       (size),
        .addr       (addr),
        .wstrb      (wstrb),
        .wdata      (wdata),
        .addr_stall (addr_stall),
        .addr_ok    (addr_ok),
        .data_ok    (data_ok),
        .rdata      (rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req = 1'b1; wr = w; addr = a; wdata = d; wstrb = s; size = 2'd2;
        step();
        req = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h0;
        wstrb = 4'h0; wdata = 32'h0; addr_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (addr_ok !== 1'b0) begin failures++; $display("FAIL reset_addr_ok: got %b expected 0", addr_ok); end
            checks++;
            if (data_ok !== 1'b0) begin failures++; $display("FAIL reset_data_ok: got %b expected 0", data_ok); end
            checks++;
            if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
        end
        resetn = 1'b1; req = 1'b0;
        #1;
        checks++;
        if (addr_ok !== 1'b1) begin failures++; $display("FAIL reset_release_addr_ok: got %b expected 1", addr_ok); end
        step();
    endtask

    task automatic test_write_read();
        req = 1'b1; wr = 1'b1; addr = 32'h10; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        #1;
        checks++;
        if (addr_ok !== 1'b1) begin failures++; $display("FAIL wr_addr_ok: got %b expected 1", addr_ok); end
        step();
        wr = 1'b0;
        step();
        req = 1'b0;
        checks++;
        if (data_ok !== 1'b0) begin failures++; $display("FAIL wr_early_beat: got %b expected 0", data_ok); end
        step();
        checks++;
        if (data_ok !== 1'b1 || rdata !== 32'h0)
            begin failures++; $display("FAIL wr_write_beat: got ok=%b rdata=%h expected ok=1 rdata=00000000", data_ok, rdata); end
        step();
        checks++;
        if (data_ok !== 1'b1 || rdata !== 32'hDEADBEEF)
            begin failures++; $display("FAIL wr_read_beat: got ok=%b rdata=%h expected ok=1 rdata=deadbeef", data_ok, rdata); end
        step();
        checks++;
        if (data_ok !== 1'b0) begin failures++; $display("FAIL wr_idle_after: got %b expected 0", data_ok); end
    endtask

    task automatic test_partial_write();
        issue(1'b1, 32'h20, 32'h11223344, 4'hF);
        issue(1'b1, 32'h20, 32'hAABBCCDD, 4'h6);
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        checks++;
        if (data_ok !== 1'b1 || rdata !== 32'h0)
            begin failures++; $display("FAIL pw_beat1: got ok=%b rdata=%h expected ok=1 rdata=00000000", data_ok, rdata); end
        step();
        checks++;
        if (data_ok !== 1'b1 || rdata !== 32'h0)
            begin failures++; $display("FAIL pw_beat2: got ok=%b rdata=%h expected ok=1 rdata=00000000", data_ok, rdata); end
        step();
        checks++;
        if (data_ok !== 1'b1 || rdata !== 32'h11BBCC44)
            begin failures++; $display("FAIL pw_merged: got ok=%b rdata=%h expected ok=1 rdata=11bbcc44", data_ok, rdata); end
        // Upper address bits and addr[1:0] are ignored: 0x40004022 aliases word 0x20.
        issue(1'b0, 32'h40004022, 32'h0, 4'h0);
        checks++;
        if (data_ok !== 1'b0) begin failures++; $display("FAIL pw_alias_early: got %b expected 0", data_ok); end
        step();
        checks++;
        if (data_ok !== 1'b0) begin failures++; $display("FAIL pw_alias_early2: got %b expected 0", data_ok); end
        step();
        checks++;
        if (data_ok !== 1'b1 || rdata !== 32'h11BBCC44)
            begin failures++; $display("FAIL pw_alias: got ok=%b rdata=%h expected ok=1 rdata=11bbcc44", data_ok, rdata); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] expq [$];
        logic [31:0] exp_d;
        logic        acc;
        int op = 0, beats = 0, cyc = 0, stalls = 0;
        while ((op < 16 || expq.size() != 0) && cyc < 60) begin
            if (op < 16) begin
                req = 1'b1; wr = (op < 8); addr = 32'h100 + 32'(4 * (op % 8));
                wdata = 32'hA500_0000 + 32'(op); wstrb = 4'hF;
            end else begin
                req = 1'b0;
            end
            #1;
            acc = req && addr_ok;
            if (req && !addr_ok) stalls++;
            @(posedge clk);
            #1;
            if (data_ok) begin
                checks++;
                beats++;
                if (expq.size() == 0) begin
                    failures++; $display("FAIL b2b_extra_beat: got rdata=%h expected no beat", rdata);
                end else begin
                    exp_d = expq.pop_front();
                    if (rdata !== exp_d) begin failures++; $display("FAIL b2b_data: got %h expected %h", rdata, exp_d); end
                end
            end
            if (acc) begin
                expq.push_back(wr ? 32'h0 : 32'hA500_0000 + 32'(op - 8));
                op++;
            end
            cyc++;
        end
        req = 1'b0;
        checks++;
        if (beats != 16) begin failures++; $display("FAIL b2b_beats: got %0d expected 16", beats); end
        checks++;
        if (stalls != 0) begin failures++; $display("FAIL b2b_stalls: got %0d expected 0", stalls); end
        checks++;
        if (cyc != 18) begin failures++; $display("FAIL b2b_cycles: got %0d expected 18", cyc); end
    endtask

    task automatic test_addr_stall();
        addr_stall = 1'b1; req = 1'b1; wr = 1'b0; addr = 32'h10;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (addr_ok !== 1'b0) begin failures++; $display("FAIL stall_addr_ok: got %b expected 0", addr_ok); end
            step();
            checks++;
            if (data_ok !== 1'b0) begin failures++; $display("FAIL stall_data_ok: got %b expected 0", data_ok); end
        end
        addr_stall = 1'b0;
        #1;
        checks++;
        if (addr_ok !== 1'b1) begin failures++; $display("FAIL stall_release: got %b expected 1", addr_ok); end
        step();
        req = 1'b0;
        checks++;
        if (data_ok !== 1'b0) begin failures++; $display("FAIL stall_early0: got %b expected 0", data_ok); end
        step();
        checks++;
        if (data_ok !== 1'b0) begin failures++; $display("FAIL stall_early1: got %b expected 0", data_ok); end
        step();
        checks++;
        if (data_ok !== 1'b1 || rdata !== 32'hDEADBEEF)
            begin failures++; $display("FAIL stall_beat: got ok=%b rdata=%h expected ok=1 rdata=deadbeef", data_ok, rdata); end
        step();
    endtask

    task automatic test_reset_midflight();
        issue(1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
        step();
        step();
        step();
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        issue(1'b0, 32'h30, 32'h0, 4'h0);
        resetn = 1'b0;
        step();
        checks++;
        if (data_ok !== 1'b0 || rdata !== 32'h0)
            begin failures++; $display("FAIL mid_reset_beat: got ok=%b rdata=%h expected ok=0 rdata=00000000", data_ok, rdata); end
        checks++;
        if (addr_ok !== 1'b0) begin failures++; $display("FAIL mid_reset_addr_ok: got %b expected 0", addr_ok); end
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (data_ok !== 1'b0) begin failures++; $display("FAIL mid_stale_beat: got %b expected 0", data_ok); end
        end
        issue(1'b0, 32'h30, 32'h0, 4'h0);
        step();
        checks++;
        if (data_ok !== 1'b0) begin failures++; $display("FAIL mid_early: got %b expected 0", data_ok); end
        step();
        checks++;
        if (data_ok !== 1'b1 || rdata !== 32'hCAFEF00D)
            begin failures++; $display("FAIL mid_readback: got ok=%b rdata=%h expected ok=1 rdata=cafef00d", data_ok, rdata); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial_write();
        test_back_to_back();
        test_addr_stall();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
